// File: rtl/fx_convert_pipe.sv
// rtl/fx_convert_pipe.sv - signed fixed-point format converter with rounding, overflow handling and delay line
module fx_convert_pipe #(
  parameter int IN_W       = 13,
  parameter int IN_FRAC    = 8,
  parameter int OUT_W      = 8,
  parameter int OUT_FRAC   = 4,
  parameter int ROUND_MODE = 1,
  parameter int SAT_MODE   = 1,
  parameter int DELAY      = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  input  logic             cnt_clr,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  output logic             o_ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int D  = IN_FRAC - OUT_FRAC;
  localparam int SH = (D > 0) ? D : 0;
  localparam int LS = (D < 0) ? -D : 0;
  // One spare MSB so the rounding increment can never carry into the sign.
  localparam int WW = IN_W + LS + 1;
  localparam int CW = ((WW > OUT_W) ? WW : OUT_W) + 1;

  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] q;
  logic signed [CW-1:0] qc;
  logic [CW-OUT_W:0]    hi;
  logic                 ovf;
  logic [OUT_W-1:0]     sat_val;
  logic [OUT_W-1:0]     q_data;

  assign ext = {{(LS+1){i_data[IN_W-1]}}, i_data} << LS;

  if (SH > 0) begin : g_round
    localparam logic [WW-1:0] HALF = {{(WW-1){1'b0}}, 1'b1} << (SH - 1);
    logic                 tie;
    logic signed [WW-1:0] add;
    logic signed [WW-1:0] sum;

    always_comb begin
      tie = (ext[SH-1:0] == HALF[SH-1:0]);
      add = '0;
      // Convergent only drops the increment on a tie whose floor is already even.
      if (ROUND_MODE == 1 || (ROUND_MODE == 2 && !(tie && !ext[SH])))
        add = HALF;
      sum = ext + add;
      q   = sum >>> SH;
    end
  end else begin : g_exact
    assign q = ext;
  end

  assign qc      = {{(CW-WW){q[WW-1]}}, q};
  assign hi      = qc[CW-1:OUT_W-1];
  assign ovf     = !((&hi) || !(|hi));
  assign sat_val = qc[CW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  assign q_data  = (ovf && SAT_MODE == 1) ? sat_val : qc[OUT_W-1:0];

  logic [DELAY-1:0] v_pipe;
  logic [DELAY-1:0] ovf_pipe;
  logic [OUT_W-1:0] d_pipe [DELAY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_pipe   <= '0;
      ovf_pipe <= '0;
      for (int i = 0; i < DELAY; i++) d_pipe[i] <= '0;
    end else begin
      // Zeroing idle slots here keeps o_data/o_ovf at 0 whenever o_valid is low.
      v_pipe[0]   <= i_valid;
      d_pipe[0]   <= i_valid ? q_data : '0;
      ovf_pipe[0] <= i_valid & ovf;
      for (int i = 1; i < DELAY; i++) begin
        v_pipe[i]   <= v_pipe[i-1];
        d_pipe[i]   <= d_pipe[i-1];
        ovf_pipe[i] <= ovf_pipe[i-1];
      end
    end
  end

  assign o_valid = v_pipe[DELAY-1];
  assign o_data  = d_pipe[DELAY-1];
  assign o_ovf   = ovf_pipe[DELAY-1];

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr)
      ovf_cnt <= '0;
    else if (o_valid && o_ovf && ovf_cnt != '1)
      ovf_cnt <= ovf_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fx_convert_pipe.sv
// tb/tb_fx_convert_pipe.sv - directed self-checking bench for fx_convert_pipe across several configurations
module tb_fx_convert_pipe;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [12:0] i_data;
  logic        cnt_clr;

  logic        ov_def, ov_cnv, ov_trn, ov_wrp, ov_d4;
  logic [7:0]  od_def, od_cnv, od_trn, od_wrp, od_d4;
  logic        of_def, of_cnv, of_trn, of_wrp, of_d4;
  logic [15:0] oc_def, oc_cnv, oc_trn, oc_wrp;
  logic [3:0]  oc_d4;

  int tests;
  int fails;

  fx_convert_pipe u_def (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .cnt_clr(cnt_clr),
    .o_valid(ov_def), .o_data(od_def), .o_ovf(of_def), .ovf_cnt(oc_def)
  );

  fx_convert_pipe #(.ROUND_MODE(2)) u_cnv (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .cnt_clr(cnt_clr),
    .o_valid(ov_cnv), .o_data(od_cnv), .o_ovf(of_cnv), .ovf_cnt(oc_cnv)
  );

  fx_convert_pipe #(.ROUND_MODE(0)) u_trn (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .cnt_clr(cnt_clr),
    .o_valid(ov_trn), .o_data(od_trn), .o_ovf(of_trn), .ovf_cnt(oc_trn)
  );

  fx_convert_pipe #(.ROUND_MODE(0), .SAT_MODE(0)) u_wrp (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .cnt_clr(cnt_clr),
    .o_valid(ov_wrp), .o_data(od_wrp), .o_ovf(of_wrp), .ovf_cnt(oc_wrp)
  );

  fx_convert_pipe #(.DELAY(4), .CNT_W(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .cnt_clr(cnt_clr),
    .o_valid(ov_d4), .o_data(od_d4), .o_ovf(of_d4), .ovf_cnt(oc_d4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle sample; returns at the negedge where DELAY=2 outputs show it.
  task automatic pulse(input logic [12:0] d);
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = '0;
    @(negedge clk);
  endtask

  logic vpat [5];

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    cnt_clr = 1'b0;
    vpat    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_def_valid", 32'(ov_def), 32'h0);
    chk("rst_def_data",  32'(od_def), 32'h0);
    chk("rst_def_ovf",   32'(of_def), 32'h0);
    chk("rst_def_cnt",   32'(oc_def), 32'h0);
    chk("rst_d4_valid",  32'(ov_d4),  32'h0);
    chk("rst_d4_cnt",    32'(oc_d4),  32'h0);
    rst_n = 1'b1;

    pulse(13'h0018);
    chk("p15_def_valid", 32'(ov_def), 32'h1);
    chk("p15_def_data",  32'(od_def), 32'h02);
    chk("p15_def_ovf",   32'(of_def), 32'h0);
    chk("p15_cnv_data",  32'(od_cnv), 32'h02);
    chk("p15_trn_data",  32'(od_trn), 32'h01);
    @(negedge clk);
    chk("p15_def_gone",  32'(ov_def), 32'h0);

    pulse(13'h1FE8);
    chk("m15_def_data",  32'(od_def), 32'hFF);
    chk("m15_cnv_data",  32'(od_cnv), 32'hFE);
    chk("m15_trn_data",  32'(od_trn), 32'hFE);

    pulse(13'h0028);
    chk("p25_def_data",  32'(od_def), 32'h03);
    chk("p25_cnv_data",  32'(od_cnv), 32'h02);

    pulse(13'h0FFF);
    chk("max_def_data",  32'(od_def), 32'h7F);
    chk("max_def_ovf",   32'(of_def), 32'h1);
    chk("max_trn_data",  32'(od_trn), 32'h7F);
    chk("max_wrp_data",  32'(od_wrp), 32'hFF);
    chk("max_wrp_ovf",   32'(of_wrp), 32'h1);

    pulse(13'h1000);
    chk("min_def_data",  32'(od_def), 32'h80);
    chk("min_def_ovf",   32'(of_def), 32'h1);
    chk("min_wrp_data",  32'(od_wrp), 32'h00);
    chk("min_wrp_ovf",   32'(of_wrp), 32'h1);

    repeat (4) @(negedge clk);
    chk("sat_def_cnt",   32'(oc_def), 32'd2);
    chk("sat_d4_cnt",    32'(oc_d4),  32'd2);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        chk("gap_d4_valid", 32'(ov_d4), 32'(vpat[i-4]));
        chk("gap_d4_data",  32'(od_d4), vpat[i-4] ? 32'((i - 3) * 16) : 32'h0);
      end
      if (i < 5) begin
        i_valid = vpat[i];
        i_data  = 13'((i + 1) * 256);
      end else begin
        i_valid = 1'b0;
        i_data  = '0;
      end
    end

    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 13'h0FFF;
    repeat (19) @(negedge clk);
    i_valid = 1'b0;
    i_data  = '0;
    repeat (6) @(negedge clk);
    chk("cnt_d4_hold",   32'(oc_d4),  32'd15);
    chk("cnt_def_21",    32'(oc_def), 32'd21);

    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 13'h0FFF;
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = '0;
    repeat (3) @(negedge clk);
    chk("clr_d4_valid",  32'(ov_d4), 32'h1);
    chk("clr_d4_ovf",    32'(of_d4), 32'h1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_d4_cnt",    32'(oc_d4), 32'd0);
    pulse(13'h0FFF);
    repeat (4) @(negedge clk);
    chk("clr_d4_next",   32'(oc_d4),  32'd1);
    chk("clr_def_next",  32'(oc_def), 32'd1);

    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 13'h0100;
    @(negedge clk);
    i_data  = 13'h0200;
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = '0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    chk("mrst_def_valid", 32'(ov_def), 32'h0);
    chk("mrst_def_cnt",   32'(oc_def), 32'd0);
    chk("mrst_d4_cnt",    32'(oc_d4),  32'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("mrst_d4_valid", 32'(ov_d4), 32'h0);
      chk("mrst_d4_data",  32'(od_d4), 32'h0);
      chk("mrst_d4_ovf",   32'(of_d4), 32'h0);
      if (j == 0) begin
        i_valid = 1'b1;
        i_data  = 13'h0300;
      end else begin
        i_valid = 1'b0;
        i_data  = '0;
      end
    end
    @(negedge clk);
    chk("post_d4_valid", 32'(ov_d4), 32'h1);
    chk("post_d4_data",  32'(od_d4), 32'h30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fx_convert_pipe.md
Name: fx_convert_pipe

Overview:
- Parametrised signed fixed-point format converter (quantization stage, then overflow stage, then a configurable delay line) with a valid qualifier and overflow reporting.
- Generalises fixed-format match blocks: arbitrary input/output width and fraction, selectable rounding and overflow modes, pipeline depth of 1 or more.
- Sits between datapath operators wherever a signal changes Q-format.

Parameters:
IN_W, 13, input word width (two's complement)
IN_FRAC, 8, input fractional bits
OUT_W, 8, output word width (two's complement)
OUT_FRAC, 4, output fractional bits
ROUND_MODE, 1, 0 = truncate (floor), 1 = round half up (ties toward +inf), 2 = convergent (ties to even)
SAT_MODE, 1, 0 = wrap, 1 = saturate
DELAY, 2, total latency in cycles, at least 1
CNT_W, 16, overflow counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_valid  in  1  input sample valid
i_data  in  IN_W  input sample, Q(IN_W-IN_FRAC).IN_FRAC
cnt_clr  in  1  synchronous clear of ovf_cnt
o_valid  out  1  output sample valid
o_data  out  OUT_W  converted sample
o_ovf  out  1  overflow occurred on this sample
ovf_cnt  out  CNT_W  saturating count of overflowed output samples

Behaviour:
- Clocking and reset
  - One clock (clk). Reset rst_n is synchronous and active-low.
  - While rst_n=0 at a rising edge: all pipeline registers, o_valid, o_data, o_ovf and ovf_cnt become 0.
  - Reset mid-stream discards all in-flight samples. No o_valid is produced for samples accepted before reset.
- Flow control
  - Streaming, no backpressure. A sample is accepted every cycle that i_valid=1.
  - A sample sampled at edge N appears at o_valid/o_data after edge N+DELAY-1, i.e. exactly DELAY cycles later.
  - Gaps in i_valid are preserved exactly.
  - When o_valid=0, o_data and o_ovf are forced to 0.
- Quantization (D = IN_FRAC - OUT_FRAC)
  - D <= 0: shift left by -D. The result is exact.
  - D > 0: remove D LSBs. The intermediate is at least one bit wider than IN_W-D, so rounding never overflows internally.
  - Truncate: arithmetic shift right.
  - Half up: add 2^(D-1), then arithmetic shift right.
  - Convergent: on an exact tie, choose the even result; otherwise behave as half up.
- Overflow
  - The quantized value is compared against [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Out of range with SAT_MODE=1: clamp to 0x80.. or 0x7F.. (sign-appropriate); o_ovf=1.
  - Out of range with SAT_MODE=0: keep the OUT_W LSBs (wrap); o_ovf=1.
  - o_ovf=1 only for samples that were actually out of range, in both modes.
- Pipeline split
  - The quantization and overflow result is registered in stage 1.
  - The remaining DELAY-1 stages are pure delay carrying {valid, data, ovf}.
- Overflow counter (ovf_cnt)
  - Increments on any cycle with o_valid=1 and o_ovf=1.
  - Holds at 2^CNT_W-1; no wrap.
  - cnt_clr=1 forces 0 and has priority over a simultaneous increment.
  - Reset also clears it.

Test Plan:
- Rounding, defaults (13,8 -> 8,4, half up, sat), single valid i_data=13'h0018 (1.5 LSB_out) -> 2 cycles later o_valid=1, o_data=8'h02, o_ovf=0; i_data=13'h1FE8 (-1.5) -> 8'hFF (-1).
- Convergent, ROUND_MODE=2: 13'h0018 -> 8'h02; 13'h0028 (2.5) -> 8'h02; 13'h1FE8 -> 8'hFE; ROUND_MODE=0: 13'h0018 -> 8'h01.
- Saturation: i_data=13'h0FFF -> 8'h7F, o_ovf=1; 13'h1000 -> 8'h80, o_ovf=1; ovf_cnt=2. With SAT_MODE=0 and ROUND_MODE=0, 13'h0FFF -> 8'hFF, o_ovf=1.
- Valid pattern: i_valid 1,0,1,1,0 with data 1,2,3,4,5 (integer-aligned), DELAY=4 -> o_valid 1,0,1,1,0 starting 4 cycles later; o_data=0 in the gap.
- Counter: force 2^CNT_W+3 overflows with CNT_W=4 -> ovf_cnt stays 15. Assert cnt_clr in the same cycle as an overflowed output -> ovf_cnt=0, then 1 on the next overflowed output.
- Reset mid-stream: rst_n=0 for 1 cycle while 2 samples are in flight -> o_valid stays 0 for those samples, all outputs 0; the next accepted sample emerges DELAY cycles after acceptance.
